// File: rtl/zeus_net_pkg.sv
// Shared constants, transmit FSM state type and header byte-order helper for the UDP/IPv4 net stack.
package zeus_net_pkg;

  localparam int unsigned ETH_HDR_BYTES   = 14;
  localparam int unsigned IP_HDR_BYTES    = 20;
  localparam int unsigned UDP_HDR_BYTES   = 8;
  localparam int unsigned HDR_BYTES       = 42;
  localparam int unsigned HDR_BITS        = HDR_BYTES * 8;
  localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP    = 8'd17;
  localparam int unsigned MAX_UDP_PAYLOAD = 1472;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_LOOKUP = 3'd1,
    TX_WAIT   = 3'd2,
    TX_HDR    = 3'd3,
    TX_STREAM = 3'd4,
    TX_FLUSH  = 3'd5,
    TX_DROP   = 3'd6
  } tx_state_e;

  // Wire-order header (first byte in the MSBs) to bus order (first byte in [7:0]).
  function automatic logic [HDR_BITS-1:0] hdr_to_bus(input logic [HDR_BITS-1:0] be);
    logic [HDR_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < HDR_BYTES; i++) begin
      r[i*8 +: 8] = be[HDR_BITS-1-i*8 -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ipv4_checksum.sv
// Ones-complement IPv4 header checksum over ten 16-bit words (checksum field supplied as zero).
module ipv4_checksum
  import zeus_net_pkg::*;
(
  input  logic [IP_HDR_BYTES*8-1:0] i_words,
  output logic [15:0]               o_csum
);

  localparam int unsigned N_WORDS = IP_HDR_BYTES / 2;

  logic [19:0] w_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;

  // Fold the end-around carry twice; the second fold can carry at most one bit.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      w_sum = w_sum + 20'(i_words[i*16 +: 16]);
    end
    w_fold1 = 17'(w_sum[15:0]) + 17'(w_sum[19:16]);
    w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);
    o_csum  = ~w_fold2;
  end

endmodule

// File: rtl/ethernet_tx.sv
// UDP/IPv4 transmit framer: resolves connection ID, prepends a 42-byte header and re-aligns onto the bus.
// Optional drop counter port tx_drop_count is built when ETHERNET_TX_DROP_STATS_EN is defined.
module ethernet_tx
  import zeus_net_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 512,
  parameter int unsigned CONN_ID_WIDTH      = 18,
  parameter logic [5:0]  IP_UDP_DSCP        = 6'd0,
  parameter logic [1:0]  IP_UDP_ENC         = 2'd0,
  parameter logic [15:0] IP_UDP_IDEN        = 16'd0,
  parameter logic [2:0]  IP_UDP_FLAGS       = 3'd0,
  parameter logic [12:0] IP_UDP_FRAG_OFFSET = 13'd0,
  parameter logic [7:0]  IP_UDP_TTL         = 8'd64
) (
  input  logic                        tx_axis_aclk,
  input  logic                        tx_axis_rst,
  input  logic [31:0]                 my_config_src_ipAddr,
  input  logic [47:0]                 my_config_src_macAddr,
  input  logic [15:0]                 my_config_src_udpPort,
  input  logic                        udp_tx_axis_tvalid,
  output logic                        udp_tx_axis_tready,
  input  logic                        udp_tx_axis_tlast,
  input  logic [DATA_WIDTH-1:0]       udp_tx_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]     udp_tx_axis_tkeep,
  input  logic [CONN_ID_WIDTH+15:0]   udp_tx_axis_tuser,
  output logic                        m01_axis_rv_lookup_valid,
  output logic [CONN_ID_WIDTH-1:0]    m01_axis_rv_lookup_connectionId,
  input  logic                        m01_axis_rv_lookup_ready,
  input  logic                        s01_axis_rv_lookup_valid,
  input  logic                        s01_axis_rv_lookup_hit,
  input  logic [31:0]                 s01_axis_rv_lookup_ipAddr,
  input  logic [15:0]                 s01_axis_rv_lookup_udpPort,
  input  logic [47:0]                 s01_axis_rv_lookup_macAddr,
  output logic                        s01_axis_rv_lookup_ready,
  output logic                        cmac_tx_axis_tvalid,
  input  logic                        cmac_tx_axis_tready,
  output logic                        cmac_tx_axis_tlast,
  output logic [DATA_WIDTH-1:0]       cmac_tx_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]     cmac_tx_axis_tkeep
`ifdef ETHERNET_TX_DROP_STATS_EN
  ,
  output logic [31:0]                 tx_drop_count
`endif
);

  localparam int unsigned KEEP_W     = DATA_WIDTH / 8;
  localparam int unsigned TAIL_BYTES = KEEP_W - HDR_BYTES;
  localparam int unsigned TAIL_BITS  = TAIL_BYTES * 8;
  localparam int unsigned USER_W     = CONN_ID_WIDTH + 16;

  tx_state_e                r_state;
  tx_state_e                w_state_nxt;
  logic [15:0]              r_len;
  logic [CONN_ID_WIDTH-1:0] r_conn_id;
  logic [31:0]              r_dst_ip;
  logic [15:0]              r_dst_port;
  logic [47:0]              r_dst_mac;
  logic [HDR_BITS-1:0]      r_carry;
  logic [KEEP_W-TAIL_BYTES-1:0] r_keep_hi;
  logic                     r_m01_valid;
  logic                     r_s01_ready;
  logic                     r_drop_ready;
  logic                     r_cmac_tvalid;
  logic                     r_cmac_tlast;
  logic [DATA_WIDTH-1:0]    r_cmac_tdata;
  logic [KEEP_W-1:0]        r_cmac_tkeep;

  logic                     w_out_free;
  logic                     w_len_ok;
  logic                     w_udp_tready;
  logic                     w_latch_user;
  logic                     w_rsp_acc;
  logic                     w_load_hdr;
  logic                     w_beat;
  logic                     w_flush;
  logic [15:0]              w_tot_len;
  logic [15:0]              w_udp_len;
  logic [15:0]              w_csum;
  logic [IP_HDR_BYTES*8-1:0] w_ip_words;
  logic [HDR_BITS-1:0]      w_hdr_be;

  assign w_out_free = !r_cmac_tvalid || cmac_tx_axis_tready;
  assign w_len_ok   = (r_len != 16'd0) && (r_len <= 16'(MAX_UDP_PAYLOAD));

  // State register.
  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_rst) r_state <= TX_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      TX_IDLE:   if (udp_tx_axis_tvalid) w_state_nxt = TX_LOOKUP;
      TX_LOOKUP: if (m01_axis_rv_lookup_ready) w_state_nxt = TX_WAIT;
      TX_WAIT:   if (s01_axis_rv_lookup_valid)
                   w_state_nxt = (s01_axis_rv_lookup_hit && w_len_ok) ? TX_HDR : TX_DROP;
      TX_HDR:    w_state_nxt = TX_STREAM;
      TX_STREAM: if (udp_tx_axis_tvalid && w_udp_tready && udp_tx_axis_tlast)
                   w_state_nxt = udp_tx_axis_tkeep[TAIL_BYTES] ? TX_FLUSH : TX_IDLE;
      TX_FLUSH:  if (w_out_free) w_state_nxt = TX_IDLE;
      TX_DROP:   if (udp_tx_axis_tvalid && udp_tx_axis_tlast) w_state_nxt = TX_IDLE;
      default:   w_state_nxt = TX_IDLE;
    endcase
  end

  // Output / datapath strobes decoded from the current state.
  always_comb begin
    w_udp_tready = r_drop_ready;
    w_latch_user = 1'b0;
    w_rsp_acc    = 1'b0;
    w_load_hdr   = 1'b0;
    w_beat       = 1'b0;
    w_flush      = 1'b0;
    unique case (r_state)
      TX_IDLE:   w_latch_user = udp_tx_axis_tvalid;
      TX_WAIT:   w_rsp_acc    = s01_axis_rv_lookup_valid && r_s01_ready;
      TX_HDR:    w_load_hdr   = 1'b1;
      TX_STREAM: begin
        w_udp_tready = w_out_free;
        w_beat       = udp_tx_axis_tvalid && w_out_free;
      end
      TX_FLUSH:  w_flush = w_out_free;
      default:   ;
    endcase
  end

  assign w_tot_len  = r_len + 16'(IP_HDR_BYTES + UDP_HDR_BYTES);
  assign w_udp_len  = r_len + 16'(UDP_HDR_BYTES);
  assign w_ip_words = {8'h45, IP_UDP_DSCP, IP_UDP_ENC, w_tot_len, IP_UDP_IDEN,
                       IP_UDP_FLAGS, IP_UDP_FRAG_OFFSET, IP_UDP_TTL, IP_PROTO_UDP,
                       16'h0000, my_config_src_ipAddr, r_dst_ip};

  ipv4_checksum u_csum (
    .i_words (w_ip_words),
    .o_csum  (w_csum)
  );

  assign w_hdr_be = {r_dst_mac, my_config_src_macAddr, ETHERTYPE_IPV4,
                     8'h45, IP_UDP_DSCP, IP_UDP_ENC, w_tot_len, IP_UDP_IDEN,
                     IP_UDP_FLAGS, IP_UDP_FRAG_OFFSET, IP_UDP_TTL, IP_PROTO_UDP,
                     w_csum, my_config_src_ipAddr, r_dst_ip,
                     my_config_src_udpPort, r_dst_port, w_udp_len, 16'h0000};

  // Registered handshakes, lookup latches, carry register and output beat.
  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_rst) begin
      r_m01_valid   <= 1'b0;
      r_s01_ready   <= 1'b0;
      r_drop_ready  <= 1'b0;
      r_conn_id     <= '0;
      r_len         <= '0;
      r_dst_ip      <= '0;
      r_dst_port    <= '0;
      r_dst_mac     <= '0;
      r_carry       <= '0;
      r_keep_hi     <= '0;
      r_cmac_tvalid <= 1'b0;
      r_cmac_tlast  <= 1'b0;
      r_cmac_tdata  <= '0;
      r_cmac_tkeep  <= '0;
    end else begin
      r_m01_valid  <= (w_state_nxt == TX_LOOKUP);
      r_s01_ready  <= (w_state_nxt == TX_WAIT);
      r_drop_ready <= (w_state_nxt == TX_DROP);
      if (w_latch_user) begin
        r_conn_id <= udp_tx_axis_tuser[CONN_ID_WIDTH-1:0];
        r_len     <= udp_tx_axis_tuser[USER_W-1 -: 16];
      end
      if (w_rsp_acc) begin
        r_dst_ip   <= s01_axis_rv_lookup_ipAddr;
        r_dst_port <= s01_axis_rv_lookup_udpPort;
        r_dst_mac  <= s01_axis_rv_lookup_macAddr;
      end
      if (w_load_hdr)  r_carry <= hdr_to_bus(w_hdr_be);
      else if (w_beat) r_carry <= udp_tx_axis_tdata[DATA_WIDTH-1:TAIL_BITS];
      if (w_beat) begin
        r_cmac_tvalid <= 1'b1;
        r_cmac_tdata  <= {udp_tx_axis_tdata[TAIL_BITS-1:0], r_carry};
        r_cmac_tkeep  <= {udp_tx_axis_tkeep[TAIL_BYTES-1:0], {HDR_BYTES{1'b1}}};
        r_cmac_tlast  <= udp_tx_axis_tlast && !udp_tx_axis_tkeep[TAIL_BYTES];
        r_keep_hi     <= udp_tx_axis_tkeep[KEEP_W-1:TAIL_BYTES];
      end else if (w_flush) begin
        r_cmac_tvalid <= 1'b1;
        r_cmac_tdata  <= {{TAIL_BITS{1'b0}}, r_carry};
        r_cmac_tkeep  <= {{TAIL_BYTES{1'b0}}, r_keep_hi};
        r_cmac_tlast  <= 1'b1;
      end else if (cmac_tx_axis_tready) begin
        r_cmac_tvalid <= 1'b0;
      end
    end
  end

  assign udp_tx_axis_tready              = w_udp_tready;
  assign m01_axis_rv_lookup_valid        = r_m01_valid;
  assign m01_axis_rv_lookup_connectionId = r_conn_id;
  assign s01_axis_rv_lookup_ready        = r_s01_ready;
  assign cmac_tx_axis_tvalid             = r_cmac_tvalid;
  assign cmac_tx_axis_tlast              = r_cmac_tlast;
  assign cmac_tx_axis_tdata              = r_cmac_tdata;
  assign cmac_tx_axis_tkeep              = r_cmac_tkeep;

`ifdef ETHERNET_TX_DROP_STATS_EN
  logic [31:0] r_drop_count;

  // Counts on entry to DROP (miss or bad length), saturating.
  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_rst) begin
      r_drop_count <= '0;
    end else if (w_rsp_acc && !(s01_axis_rv_lookup_hit && w_len_ok) &&
                 (r_drop_count != 32'hFFFF_FFFF)) begin
      r_drop_count <= r_drop_count + 32'd1;
    end
  end

  assign tx_drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_ethernet_tx.sv
// Directed self-checking bench for ethernet_tx: framing, re-alignment, drops and back-pressure.
module tb_ethernet_tx;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  src_ip;
  logic [47:0]  src_mac;
  logic [15:0]  src_port;
  logic         udp_tvalid, udp_tready, udp_tlast;
  logic [511:0] udp_tdata;
  logic [63:0]  udp_tkeep;
  logic [33:0]  udp_tuser;
  logic         m01_valid, m01_ready;
  logic [17:0]  m01_id;
  logic         s01_valid, s01_hit, s01_ready;
  logic [31:0]  s01_ip;
  logic [15:0]  s01_port;
  logic [47:0]  s01_mac;
  logic         cmac_tvalid, cmac_tready, cmac_tlast;
  logic [511:0] cmac_tdata;
  logic [63:0]  cmac_tkeep;
`ifdef ETHERNET_TX_DROP_STATS_EN
  logic [31:0]  drop_count;
`endif

  always #5 clk = ~clk;

  ethernet_tx dut (
    .tx_axis_aclk(clk), .tx_axis_rst(rst),
    .my_config_src_ipAddr(src_ip), .my_config_src_macAddr(src_mac),
    .my_config_src_udpPort(src_port),
    .udp_tx_axis_tvalid(udp_tvalid), .udp_tx_axis_tready(udp_tready),
    .udp_tx_axis_tlast(udp_tlast), .udp_tx_axis_tdata(udp_tdata),
    .udp_tx_axis_tkeep(udp_tkeep), .udp_tx_axis_tuser(udp_tuser),
    .m01_axis_rv_lookup_valid(m01_valid), .m01_axis_rv_lookup_connectionId(m01_id),
    .m01_axis_rv_lookup_ready(m01_ready),
    .s01_axis_rv_lookup_valid(s01_valid), .s01_axis_rv_lookup_hit(s01_hit),
    .s01_axis_rv_lookup_ipAddr(s01_ip), .s01_axis_rv_lookup_udpPort(s01_port),
    .s01_axis_rv_lookup_macAddr(s01_mac), .s01_axis_rv_lookup_ready(s01_ready),
    .cmac_tx_axis_tvalid(cmac_tvalid), .cmac_tx_axis_tready(cmac_tready),
    .cmac_tx_axis_tlast(cmac_tlast), .cmac_tx_axis_tdata(cmac_tdata),
    .cmac_tx_axis_tkeep(cmac_tkeep)
`ifdef ETHERNET_TX_DROP_STATS_EN
    ,
    .tx_drop_count(drop_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lookup responder: ID 5 hits at 10.0.0.2:5000, 02:00:00:00:00:02; everything else misses.
  int          cyc = 0;
  int          rsp_cyc = 0;
  logic [17:0] last_id = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      s01_valid <= 1'b0;
    end else begin
      if (s01_valid && s01_ready) begin
        s01_valid <= 1'b0;
        rsp_cyc   <= cyc;
      end
      if (m01_valid && m01_ready) begin
        s01_valid <= 1'b1;
        s01_hit   <= (m01_id == 18'd5);
        last_id   <= m01_id;
      end
    end
  end

  // Output monitor: captures accepted beats and checks hold-while-stalled.
  logic [511:0] q_data[$];
  logic [63:0]  q_keep[$];
  logic         q_last[$];
  int           n_last = 0;
  int           n_stalls = 0;
  int           first_valid_cyc = 0;
  logic         p_stall = 1'b0, p_valid = 1'b0, p_last = 1'b0;
  logic [511:0] p_data = '0;
  logic [63:0]  p_keep = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (p_stall) begin
        n_stalls <= n_stalls + 1;
        check("stall_hold", 64'({cmac_tvalid, cmac_tdata == p_data, cmac_tkeep == p_keep,
                                 cmac_tlast == p_last}), 64'hF);
      end
      if (cmac_tvalid && cmac_tready) begin
        q_data.push_back(cmac_tdata);
        q_keep.push_back(cmac_tkeep);
        q_last.push_back(cmac_tlast);
        if (cmac_tlast) n_last <= n_last + 1;
      end
      if (cmac_tvalid && !p_valid) first_valid_cyc <= cyc;
    end
    p_stall <= cmac_tvalid && !cmac_tready;
    p_valid <= cmac_tvalid;
    p_data  <= cmac_tdata;
    p_keep  <= cmac_tkeep;
    p_last  <= cmac_tlast;
  end

  // CMAC back-pressure: always ready, or toggling 1,0,1,0 when stall_mode is set.
  logic stall_mode = 1'b0;
  initial begin
    cmac_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cmac_tready = stall_mode ? ~cmac_tready : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  logic [7:0] q_exp[$];
  logic [7:0] q_got[$];
  logic [7:0] q_ref[$];

  function automatic logic [15:0] exp_csum(input int len);
    logic [31:0] s;
    s = 32'h4500 + 32'(len + 28) + 32'h4011 + 32'h0A00 + 32'h0001 + 32'h0A00 + 32'h0002;
    s = (s & 32'hFFFF) + (s >> 16);
    s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  task automatic make_exp(input int len, input int seed);
    logic [15:0] tot, ulen, cs;
    logic [7:0]  hdr[42];
    tot = 16'(len + 28); ulen = 16'(len + 8); cs = exp_csum(len);
    hdr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
            8'h08, 8'h00, 8'h45, 8'h00, tot[15:8], tot[7:0], 8'h00, 8'h00, 8'h00, 8'h00,
            8'h40, 8'h11, cs[15:8], cs[7:0], 8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00,
            8'h00, 8'h02, 8'h12, 8'h34, 8'h13, 8'h88, ulen[15:8], ulen[7:0], 8'h00, 8'h00};
    q_exp.delete();
    for (int i = 0; i < 42; i++) q_exp.push_back(hdr[i]);
    for (int j = 0; j < len; j++) q_exp.push_back(8'(seed + j));
  endtask

  task automatic collect(input int base);
    q_got.delete();
    for (int b = base; b < q_data.size(); b++)
      for (int i = 0; i < 64; i++)
        if (q_keep[b][i]) q_got.push_back(q_data[b][i*8 +: 8]);
  endtask

  task automatic cmp_bytes(input string tag);
    int mism;
    mism = 0;
    check({tag, "_nbytes"}, 64'(q_got.size()), 64'(q_exp.size()));
    for (int i = 0; i < q_got.size() && i < q_exp.size(); i++)
      if (q_got[i] !== q_exp[i]) mism++;
    check({tag, "_bytes"}, 64'(mism), 64'd0);
  endtask

  task automatic send_pkt(input int id, input int len, input int seed);
    int   nb;
    logic acc;
    nb = (len == 0) ? 1 : (len + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 64; i++) begin
        int j;
        j = b * 64 + i;
        udp_tdata[i*8 +: 8] = (j < len) ? 8'(seed + j) : 8'h00;
        udp_tkeep[i]        = (j < len);
      end
      udp_tlast  = (b == nb - 1);
      udp_tuser  = {16'(len), 18'(id)};
      udp_tvalid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 300 && !acc; t++) begin
        @(negedge clk); acc = udp_tready;
        @(posedge clk); #1;
      end
      check("in_accept", 64'(acc), 64'd1);
    end
    udp_tvalid = 1'b0;
    udp_tlast  = 1'b0;
  endtask

  task automatic wait_frame(input int target);
    for (int t = 0; t < 200 && n_last < target; t++) @(posedge clk);
    check("frame_done", 64'(n_last >= target), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic hdr_sum(output logic [15:0] r);
    logic [31:0] s;
    s = 0;
    for (int i = 14; i < 34; i += 2) s = s + {16'h0, q_got[i], q_got[i+1]};
    s = (s & 32'hFFFF) + (s >> 16);
    s = (s & 32'hFFFF) + (s >> 16);
    r = s[15:0];
  endtask

  int          base;
  int          drop_ids[3]  = '{9, 5, 5};
  int          drop_lens[3] = '{150, 1473, 0};
  logic [15:0] hs;

  initial begin
    src_ip = 32'h0A00_0001; src_mac = 48'h02_00_00_00_00_01; src_port = 16'h1234;
    s01_ip = 32'h0A00_0002; s01_port = 16'd5000; s01_mac = 48'h02_00_00_00_00_02;
    udp_tvalid = 1'b0; udp_tlast = 1'b0; udp_tdata = '0; udp_tkeep = '0; udp_tuser = '0;
    m01_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmac_tvalid", 64'(cmac_tvalid), 64'd0);
    check("rst_cmac_tkeep", cmac_tkeep, 64'd0);
    check("rst_udp_tready", 64'(udp_tready), 64'd0);
    check("rst_m01_valid", 64'({m01_valid, s01_ready, cmac_tlast}), 64'd0);
    check("rst_m01_id", 64'(m01_id), 64'd0);
`ifdef ETHERNET_TX_DROP_STATS_EN
    check("rst_drop_count", 64'(drop_count), 64'd0);
`endif
    rst = 1'b0;

    // Single beat, len 10.
    base = q_data.size();
    send_pkt(5, 10, 8'h10);
    wait_frame(1);
    make_exp(10, 8'h10); collect(base);
    check("t1_id", 64'(last_id), 64'd5);
    check("t1_beats", 64'(q_data.size() - base), 64'd1);
    check("t1_keep", q_keep[base], 64'h000F_FFFF_FFFF_FFFF);
    check("t1_last", 64'(q_last[base]), 64'd1);
    check("t1_latency", 64'(first_valid_cyc - rsp_cyc), 64'd3);
    check("t1_ip_len", 64'({q_got[16], q_got[17]}), 64'h0026);
    check("t1_udp_len", 64'({q_got[38], q_got[39]}), 64'h0012);
    check("t1_csum", 64'({q_got[24], q_got[25]}), 64'h66C5);
    hdr_sum(hs);
    check("t1_csum_verify", 64'(hs), 64'hFFFF);
    cmp_bytes("t1");

    // 64 + 22 byte payload: exact fit, no flush.
    base = q_data.size();
    send_pkt(5, 86, 8'h80);
    wait_frame(2);
    make_exp(86, 8'h80); collect(base);
    check("t2_beats", 64'(q_data.size() - base), 64'd2);
    check("t2_keep0", q_keep[base], 64'hFFFF_FFFF_FFFF_FFFF);
    check("t2_keep1", q_keep[base+1], 64'hFFFF_FFFF_FFFF_FFFF);
    check("t2_last", 64'({q_last[base], q_last[base+1]}), 64'b01);
    cmp_bytes("t2");

    // Len 23: one byte spills into the flush beat.
    base = q_data.size();
    send_pkt(5, 23, 8'hC3);
    wait_frame(3);
    make_exp(23, 8'hC3); collect(base);
    check("t3_beats", 64'(q_data.size() - base), 64'd2);
    check("t3_keep0", q_keep[base], 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3_keep1", q_keep[base+1], 64'h1);
    check("t3_last", 64'({q_last[base], q_last[base+1]}), 64'b01);
    cmp_bytes("t3");

    // Drops: miss, oversize with hit, zero length with hit.
    for (int d = 0; d < 3; d++) begin
      base = q_data.size();
      send_pkt(drop_ids[d], drop_lens[d], 8'h33);
      repeat (20) @(posedge clk);
      #1;
      check("drop_no_output", 64'(q_data.size() - base), 64'd0);
`ifdef ETHERNET_TX_DROP_STATS_EN
      check("drop_count", 64'(drop_count), 64'(d + 1));
`endif
    end

    // Valid packet after drops, with flush.
    base = q_data.size();
    send_pkt(5, 30, 8'h5A);
    wait_frame(4);
    make_exp(30, 8'h5A); collect(base);
    check("t5_beats", 64'(q_data.size() - base), 64'd2);
    cmp_bytes("t5");

    // Five input beats, unstalled reference run.
    base = q_data.size();
    send_pkt(5, 300, 8'h07);
    wait_frame(5);
    make_exp(300, 8'h07); collect(base);
    check("t6_beats", 64'(q_data.size() - base), 64'd6);
    check("t6_keep_last", q_keep[base+5], 64'h3F_FFFF);
    cmp_bytes("t6");
    q_ref = q_got;

    // Same packet with CMAC tready toggling.
    stall_mode = 1'b1;
    base = q_data.size();
    send_pkt(5, 300, 8'h07);
    wait_frame(6);
    stall_mode = 1'b0;
    collect(base);
    q_exp = q_ref;
    cmp_bytes("t7_vs_unstalled");
    check("t7_stalls_seen", 64'(n_stalls != 0), 64'd1);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ethernet_tx.md
# ethernet_tx

Transmit-side UDP/IPv4 framer; counterpart of the receive path. It accepts user payload packets tagged with a connection ID and resolves the ID through the connection manager's reverse-lookup channel. It then prepends a 42-byte Ethernet/IPv4/UDP header, re-aligned onto the 512-bit bus, and streams frames to the CMAC TX port. Packets whose ID misses are consumed and discarded.

## Interface
- DATA_WIDTH, 512: bus width; only 512 supported.
- CONN_ID_WIDTH, 18: connection ID width, matching the connection manager.
- IP_UDP_DSCP, 0 / IP_UDP_ENC, 0 / IP_UDP_IDEN, 0 / IP_UDP_FLAGS, 0 / IP_UDP_FRAG_OFFSET, 0 / IP_UDP_TTL, 64: constant IPv4 header fields.
- tx_axis_aclk  in  1  sole clock.
- tx_axis_rst  in  1  reset; synchronous, active-high.
- my_config_src_ipAddr / my_config_src_macAddr / my_config_src_udpPort  in  32/48/16  local addresses.
- udp_tx_axis_tvalid / tready / tlast  in/out/in  1  user payload stream.
- udp_tx_axis_tdata / tkeep  in  512/64  payload; byte 0 is in [7:0]; tkeep is contiguous from bit 0.
- udp_tx_axis_tuser  in  CONN_ID_WIDTH+16  [CONN_ID_WIDTH-1:0] = connection ID, upper 16 bits = payload length in bytes; sampled on the first beat only.
- m01_axis_rv_lookup_valid / connectionId / ready  out/out/in  1/CONN_ID_WIDTH/1  reverse-lookup request.
- s01_axis_rv_lookup_valid / hit / ipAddr / udpPort / macAddr / ready  in×5/out  1/1/32/16/48/1  reverse-lookup response.
- cmac_tx_axis_tvalid / tready / tlast / tdata / tkeep  out/in/out/out/out  1/1/1/512/64  frame to CMAC.
- tx_drop_count  out  32  dropped-packet count; present only when the macro in Configuration is defined.

## Operation
- FSM states:
  - IDLE: `udp tready=0`. Go to LOOKUP when `udp tvalid` is high; latch tuser at that point.
  - LOOKUP: `m01 valid=1` with the latched ID, held until `m01 ready`; then go to WAIT.
  - WAIT: `s01 ready=1`. On `s01 valid`, a hit goes to HDR and a miss goes to DROP.
  - HDR: one cycle. Builds the header register and registers the IPv4 checksum.
  - STREAM: accepts and emits beats.
  - FLUSH: emits the remaining carry bytes.
  - DROP: `udp tready=1`; discards beats through tlast, then returns to IDLE.
- A length of 0 or greater than 1472 forces DROP after the lookup completes, whatever the hit result.
- Header byte order on the wire is big-endian:
  - Ethernet: dst = lookup MAC, src = config MAC, type 0x0800.
  - IPv4: 0x45, {DSCP,ENC}, total length = len+28, IDEN, {FLAGS,FRAG_OFFSET}, TTL, protocol 17, checksum, src = config IP, dst = lookup IP.
  - UDP: src = config port, dst = lookup port, length = len+8, checksum 0x0000.
- IPv4 checksum: ones-complement of the 16-bit ones-complement sum of the 10 header words, with end-around carry folded twice.
- Re-alignment uses a 42-byte carry register, loaded with the header in HDR.
  - Each accepted input beat produces an output beat with bytes[41:0] = carry and bytes[63:42] = input bytes[21:0].
  - Input bytes[63:22] then become the new carry.
- At the input tlast beat, let `k` = popcount(tkeep):
  - `k ≤ 22`: the output beat is last, with `tkeep = {in_keep[21:0], 42'h3FF_FFFF_FFFF}`. Return to IDLE.
  - `k > 22`: the output beat is not last. Go to FLUSH, which emits the carry with `tkeep = in_keep[63:22]` and tlast, then returns to IDLE.
- The payload length in tuser is trusted for the header; it is not checked against the tkeep total.

## Timing
- Outputs are registered. Reset values: all valids, readies, tlast, tdata, tkeep, m01 connectionId and tx_drop_count are 0. State resets to IDLE.
- In STREAM, `udp tready = !cmac_tvalid || cmac_tready`. It is 0 in FLUSH while the flush beat is stalled.
- cmac tdata, tkeep and tlast stay stable while `tvalid && !tready`.
- Pipeline timing:
  - First `udp tvalid` seen at cycle T, so m01 valid is asserted from T+1.
  - A response accepted at cycle R puts HDR at R+1.
  - The earliest first-beat accept is at R+2, and cmac tvalid first rises at R+3.
  - After that, one output beat per accepted input beat, with one extra beat for FLUSH.
- Throughput is one beat per cycle when unstalled. The next packet's lookup starts in the cycle after returning to IDLE.
- Reset mid-packet aborts the frame: cmac tvalid drops the next cycle with no tlast. The next `udp tvalid` is treated as a packet start.

## Configuration
- ETHERNET_TX_DROP_STATS_EN:
  - Defined: the tx_drop_count port exists. It increments once per dropped packet (miss or bad length) on DROP entry and saturates at 0xFFFF_FFFF.
  - Undefined: no port, no counter logic; dropping behaviour is identical.

## Structure
- Shared package zeus_net_pkg holds:
  - constants ETH_HDR_BYTES=14, IP_HDR_BYTES=20, UDP_HDR_BYTES=8, HDR_BYTES=42, ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'd17, MAX_UDP_PAYLOAD=1472;
  - the tx state enum.
- Sub-module ipv4_checksum: a 10-word ones-complement sum, instantiated in the HDR stage.

## Test plan
- ID 5 → hit (10.0.0.2:5000, MAC 02:00:00:00:00:02), len 10, single input beat → one output beat with tkeep=64'h000F_FFFF_FFFF_FFFF, tlast=1, IP total length 0x0026, UDP length 0x0012, checksum that verifies to 0xFFFF.
- Len 86 in two input beats (64+22 bytes) → exactly two output beats, both tkeep all-ones, the second with tlast; payload is byte-exact.
- Len 23 → two output beats; the flush beat has tkeep=64'h1 and tlast.
- Lookup miss on a 3-beat packet → all three beats accepted, no cmac tvalid, tx_drop_count goes 0→1.
- Len 1473 with a hit → packet dropped; the next valid packet is framed correctly.
- cmac tready toggling 1,0,1,0 over a 5-beat packet → output stable while stalled, with a byte stream identical to the unstalled run.
